// File: rtl/voxguard_spi_pkg.sv
// Shared SPI definitions for the packet-manager/RF-transceiver link:
// FSM state codes, SPI mode, byte width and the default poll byte.
package voxguard_spi_pkg;

    localparam int BYTE_W = 8;
    localparam int BIT_W  = $clog2(BYTE_W);

    // Mode 0: SCLK idles low, data is sampled on the rising edge.
    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

    localparam logic [BYTE_W-1:0] DEFAULT_DUMMY_BYTE = 8'h00;

    typedef logic [2:0] spi_state_t;

    localparam spi_state_t ST_IDLE     = 3'd0;
    localparam spi_state_t ST_SETUP    = 3'd1;
    localparam spi_state_t ST_SCK_HIGH = 3'd2;
    localparam spi_state_t ST_SCK_LOW  = 3'd3;
    localparam spi_state_t ST_HOLD     = 3'd4;

endpackage

// File: rtl/spi_byte_transceiver_phase_timer.sv
// Half-period counter: strobes phase_end on the last clk cycle of each
// CLK_DIV-long SPI phase; held at zero while clear is high.
module spi_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic phase_end
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign phase_end = !clear && (cnt == CW'(CLK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || clear || phase_end)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/spi_byte_transceiver.sv
// Full-duplex mode-0 SPI byte master with a one-deep request slot and
// automatic dummy polling transfers while idle.
module spi_byte_transceiver
    import voxguard_spi_pkg::*;
#(
    parameter int                CLK_DIV    = 4,
    parameter int                POLL_GAP   = 16,
    parameter logic [BYTE_W-1:0] DUMMY_BYTE = DEFAULT_DUMMY_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [BYTE_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_overrun,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_done,
    input  logic              poll_en,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int PW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    spi_state_t        state;
    logic [BYTE_W-1:0] shift;
    logic [BYTE_W-1:0] pend_data;
    logic              pend_valid;
    logic [BIT_W-1:0]  bit_cnt;
    logic [PW-1:0]     poll_cnt;
    logic              phase_end;
    logic              launch;
    logic [BYTE_W-1:0] launch_byte;

    spi_phase_timer #(.CLK_DIV(CLK_DIV)) u_phase_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state == ST_IDLE),
        .phase_end (phase_end)
    );

    // Busy covers both the active transfer and a waiting request.
    assign tx_busy = (state != ST_IDLE) || pend_valid;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        launch      = 1'b0;
        launch_byte = DUMMY_BYTE;
        if (state == ST_IDLE) begin
            if (pend_valid) begin
                launch      = 1'b1;
                launch_byte = pend_data;
            end else if (tx_start) begin
                launch      = 1'b1;
                launch_byte = tx_data;
            end else if (poll_en && poll_cnt == PW'(POLL_GAP - 1)) begin
                launch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            sclk       <= SPI_CPOL;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            tx_overrun <= 1'b0;
            rx_data    <= '0;
            rx_done    <= 1'b0;
            shift      <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
            bit_cnt    <= '0;
            poll_cnt   <= '0;
        end else begin
            rx_done    <= 1'b0;
            tx_overrun <= 1'b0;

            if (tx_start && tx_busy) begin
                if (pend_valid) begin
                    tx_overrun <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_data  <= tx_data;
                end
            end

            if (launch || !poll_en)
                poll_cnt <= '0;
            else if (state == ST_IDLE)
                poll_cnt <= poll_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        pend_valid <= 1'b0;
                        state      <= ST_SETUP;
                        cs_n       <= 1'b0;
                        shift      <= launch_byte;
                        mosi       <= launch_byte[BYTE_W-1];
                        bit_cnt    <= '0;
                    end
                end
                ST_SETUP: begin
                    if (phase_end) begin
                        state <= ST_SCK_HIGH;
                        sclk  <= ~SPI_CPOL;
                        shift <= {shift[BYTE_W-2:0], miso};
                    end
                end
                ST_SCK_HIGH: begin
                    if (phase_end) begin
                        state <= ST_SCK_LOW;
                        sclk  <= SPI_CPOL;
                        // The shift has already moved, so bit 7 is the next MOSI bit.
                        if (bit_cnt != BIT_W'(BYTE_W - 1))
                            mosi <= shift[BYTE_W-1];
                    end
                end
                ST_SCK_LOW: begin
                    if (phase_end) begin
                        if (bit_cnt == BIT_W'(BYTE_W - 1)) begin
                            state <= ST_HOLD;
                        end else begin
                            state   <= ST_SCK_HIGH;
                            sclk    <= ~SPI_CPOL;
                            shift   <= {shift[BYTE_W-2:0], miso};
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (phase_end) begin
                        // A pending byte launches from IDLE next cycle, giving cs_n one high cycle.
                        state   <= ST_IDLE;
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        rx_data <= shift;
                        rx_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
